// File: rtl/fht_but_array_if.sv
// Sample bus for the Hartley butterfly array.
// Inputs: valid, ordering/scale flags, packed X0/X1/X2/cos/sin; outputs: valid, permuted Y, sticky overflow.
interface fht_but_array_if #(
    parameter int D_BIT   = 17,
    parameter int W_BIT   = 12,
    parameter int NUM_BUT = 2
);
    logic                         iVALID;
    logic                         iST_LAST;
    logic                         i2ND_PART_SUBSEC;
    logic                         iSCALE;
    logic                         iCLR_OVF;
    logic [NUM_BUT*D_BIT-1:0]     iX0;
    logic [NUM_BUT*D_BIT-1:0]     iX1;
    logic [NUM_BUT*D_BIT-1:0]     iX2;
    logic [NUM_BUT*W_BIT-1:0]     iCOS;
    logic [NUM_BUT*W_BIT-1:0]     iSIN;
    logic                         oVALID;
    logic [2*NUM_BUT*D_BIT-1:0]   oY;
    logic                         oOVF;

    modport master (
        output iVALID, iST_LAST, i2ND_PART_SUBSEC, iSCALE, iCLR_OVF,
        output iX0, iX1, iX2, iCOS, iSIN,
        input  oVALID, oY, oOVF
    );

    modport slave (
        input  iVALID, iST_LAST, i2ND_PART_SUBSEC, iSCALE, iCLR_OVF,
        input  iX0, iX1, iX2, iCOS, iSIN,
        output oVALID, oY, oOVF
    );
endinterface

// File: rtl/fht_but_array.sv
// NUM_BUT radix-2 Hartley butterflies, Y0/Y1 = X0 +/- (X1*cos + X2*sin).
// Ports: iCLK, iRESET (async low), bus (slave): samples in, permuted/scaled/saturated Y out.
module fht_but_array #(
    parameter int D_BIT   = 17,
    parameter int W_BIT   = 12,
    parameter int NUM_BUT = 2
) (
    input  logic           iCLK,
    input  logic           iRESET,
    fht_but_array_if.slave bus
);
    localparam int PW = D_BIT + W_BIT;
    localparam int SW = PW + 1;
    localparam int AW = D_BIT + 2;
    localparam int NY = 2 * NUM_BUT;

    localparam logic signed [SW-1:0] RND  = SW'(1) << (W_BIT - 3);
    localparam logic signed [AW:0]   ONE  = (AW+1)'(1);
    localparam logic signed [AW:0]   MAXV = (AW+1)'((1 << (D_BIT - 1)) - 1);
    localparam logic signed [AW:0]   MINV = (AW+1)'(-(1 << (D_BIT - 1)));

    // Input capture keeps the multipliers between flops.
    logic                    r_s0_v, r_s0_sc, r_s0_last, r_s0_mir;
    logic signed [D_BIT-1:0] r_s0_x0 [NUM_BUT];
    logic signed [D_BIT-1:0] r_s0_x1 [NUM_BUT];
    logic signed [D_BIT-1:0] r_s0_x2 [NUM_BUT];
    logic signed [W_BIT-1:0] r_s0_c  [NUM_BUT];
    logic signed [W_BIT-1:0] r_s0_s  [NUM_BUT];

    logic                    r_s1_v, r_s1_sc, r_s1_last, r_s1_mir;
    logic signed [D_BIT-1:0] r_s1_x0 [NUM_BUT];
    logic signed [PW-1:0]    r_s1_p1 [NUM_BUT];
    logic signed [PW-1:0]    r_s1_p2 [NUM_BUT];

    logic                    r_s2_v, r_s2_sc, r_s2_last, r_s2_mir;
    logic signed [AW-1:0]    r_s2_a  [NUM_BUT];
    logic signed [AW-1:0]    r_s2_b  [NUM_BUT];

    logic                    r_s3_v, r_ovf;
    logic [NY*D_BIT-1:0]     r_y;

    logic signed [PW-1:0]    w_p1 [NUM_BUT];
    logic signed [PW-1:0]    w_p2 [NUM_BUT];
    logic signed [SW-1:0]    w_p  [NUM_BUT];
    logic signed [SW-1:0]    w_t  [NUM_BUT];
    logic signed [AW-1:0]    w_a  [NUM_BUT];
    logic signed [AW-1:0]    w_b  [NUM_BUT];
    logic [D_BIT-1:0]        w_sa [NUM_BUT];
    logic [D_BIT-1:0]        w_sb [NUM_BUT];
    logic                    w_oa [NUM_BUT];
    logic                    w_ob [NUM_BUT];
    logic [D_BIT-1:0]        w_y  [NY];
    logic                    w_ovf;

    // Optional halving with round-half-up, then clamp; MSB flags a clamp.
    function automatic logic [D_BIT:0] f_sat(
        input logic signed [AW-1:0] v,
        input logic                 sc
    );
        logic signed [AW:0] e;
        e = (AW+1)'(v);
        if (sc) e = (e + ONE) >>> 1;
        if (e > MAXV) return {1'b1, MAXV[D_BIT-1:0]};
        if (e < MINV) return {1'b1, MINV[D_BIT-1:0]};
        return {1'b0, e[D_BIT-1:0]};
    endfunction

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_s0_v    <= 1'b0;
            r_s0_sc   <= 1'b0;
            r_s0_last <= 1'b0;
            r_s0_mir  <= 1'b0;
            for (int k = 0; k < NUM_BUT; k++) begin
                r_s0_x0[k] <= '0;
                r_s0_x1[k] <= '0;
                r_s0_x2[k] <= '0;
                r_s0_c[k]  <= '0;
                r_s0_s[k]  <= '0;
            end
        end else begin
            r_s0_v    <= bus.iVALID;
            r_s0_sc   <= bus.iSCALE;
            r_s0_last <= bus.iST_LAST;
            r_s0_mir  <= bus.i2ND_PART_SUBSEC;
            for (int k = 0; k < NUM_BUT; k++) begin
                r_s0_x0[k] <= bus.iX0[k*D_BIT +: D_BIT];
                r_s0_x1[k] <= bus.iX1[k*D_BIT +: D_BIT];
                r_s0_x2[k] <= bus.iX2[k*D_BIT +: D_BIT];
                r_s0_c[k]  <= bus.iCOS[k*W_BIT +: W_BIT];
                r_s0_s[k]  <= bus.iSIN[k*W_BIT +: W_BIT];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_BUT; k++) begin
            w_p1[k] = PW'(r_s0_x1[k]) * PW'(r_s0_c[k]);
            w_p2[k] = PW'(r_s0_x2[k]) * PW'(r_s0_s[k]);
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_s1_v    <= 1'b0;
            r_s1_sc   <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_mir  <= 1'b0;
            for (int k = 0; k < NUM_BUT; k++) begin
                r_s1_x0[k] <= '0;
                r_s1_p1[k] <= '0;
                r_s1_p2[k] <= '0;
            end
        end else begin
            r_s1_v    <= r_s0_v;
            r_s1_sc   <= r_s0_sc;
            r_s1_last <= r_s0_last;
            r_s1_mir  <= r_s0_mir;
            for (int k = 0; k < NUM_BUT; k++) begin
                r_s1_x0[k] <= r_s0_x0[k];
                r_s1_p1[k] <= w_p1[k];
                r_s1_p2[k] <= w_p2[k];
            end
        end
    end

    // T drops the Q1 fraction bits with round-half-up.
    always_comb begin
        for (int k = 0; k < NUM_BUT; k++) begin
            w_p[k] = SW'(r_s1_p1[k]) + SW'(r_s1_p2[k]);
            w_t[k] = (w_p[k] + RND) >>> (W_BIT - 2);
            w_a[k] = AW'(r_s1_x0[k]) + $signed(w_t[k][AW-1:0]);
            w_b[k] = AW'(r_s1_x0[k]) - $signed(w_t[k][AW-1:0]);
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_s2_v    <= 1'b0;
            r_s2_sc   <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_mir  <= 1'b0;
            for (int k = 0; k < NUM_BUT; k++) begin
                r_s2_a[k] <= '0;
                r_s2_b[k] <= '0;
            end
        end else begin
            r_s2_v    <= r_s1_v;
            r_s2_sc   <= r_s1_sc;
            r_s2_last <= r_s1_last;
            r_s2_mir  <= r_s1_mir;
            for (int k = 0; k < NUM_BUT; k++) begin
                r_s2_a[k] <= w_a[k];
                r_s2_b[k] <= w_b[k];
            end
        end
    end

    // Last-stage interleave beats the mirrored order.
    always_comb begin
        w_ovf = 1'b0;
        for (int j = 0; j < NY; j++) w_y[j] = '0;
        for (int k = 0; k < NUM_BUT; k++) begin
            {w_oa[k], w_sa[k]} = f_sat(r_s2_a[k], r_s2_sc);
            {w_ob[k], w_sb[k]} = f_sat(r_s2_b[k], r_s2_sc);
            w_ovf = w_ovf | w_oa[k] | w_ob[k];
        end
        for (int k = 0; k < NUM_BUT; k++) begin
            if (r_s2_last) begin
                w_y[2*k]   = w_sa[k];
                w_y[2*k+1] = w_sb[k];
            end else if (r_s2_mir) begin
                w_y[k]         = w_sa[NUM_BUT-1-k];
                w_y[NUM_BUT+k] = w_sb[NUM_BUT-1-k];
            end else begin
                w_y[k]         = w_sa[k];
                w_y[NUM_BUT+k] = w_sb[k];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_s3_v <= 1'b0;
            r_y    <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
                for (int j = 0; j < NY; j++)
                    r_y[j*D_BIT +: D_BIT] <= w_y[j];
            end
            // A fresh saturation wins over a coincident clear.
            if (r_s2_v && w_ovf)
                r_ovf <= 1'b1;
            else if (bus.iCLR_OVF)
                r_ovf <= 1'b0;
        end
    end

    assign bus.oVALID = r_s3_v;
    assign bus.oY     = r_y;
    assign bus.oOVF   = r_ovf;
endmodule

// File: tb/tb_fht_but_array.sv
// Bench for fht_but_array: constant vector table, corner sequences,
// and randomized samples scored against an arithmetic reference model.
module tb_fht_but_array;
    localparam int D  = 17;
    localparam int W  = 12;
    localparam int NB = 2;
    localparam int NY = 2 * NB;
    localparam int YW = NY * D;
    localparam int MAXV = (1 << (D - 1)) - 1;
    localparam int MINV = -(1 << (D - 1));

    logic iCLK = 1'b0;
    logic iRESET = 1'b0;
    always #5 iCLK = ~iCLK;

    fht_but_array_if #(.D_BIT(D), .W_BIT(W), .NUM_BUT(NB)) bus ();

    fht_but_array #(.D_BIT(D), .W_BIT(W), .NUM_BUT(NB)) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    typedef struct {
        int x0a, x0b, x1a, x1b, x2a, x2b;
        int c0, c1, s0, s1;
        int sc, lst, mir;
        int y0, y1, y2, y3;
        int ovf;
    } vec_t;

    typedef struct {
        int          due;
        logic [YW-1:0] y;
        logic        ov;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    logic sticky = 1'b0;
    exp_t q[$];
    vec_t tbl[11];
    int   sx0[NB], sx1[NB], sx2[NB], scs[NB], ss[NB];

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk_y(input string nm, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input longint v, inout logic o);
        if (v > MAXV) begin o = 1'b1; return MAXV; end
        if (v < MINV) begin o = 1'b1; return MINV; end
        return int'(v);
    endfunction

    function automatic void ref_lane(input int x0, x1, x2, c, s, input logic sc,
                                     output int a, output int b, output logic o);
        longint p, t, va, vb;
        p  = longint'(x1) * longint'(c) + longint'(x2) * longint'(s);
        t  = (p + (longint'(1) <<< (W - 3))) >>> (W - 2);
        va = x0 + t;
        vb = x0 - t;
        if (sc) begin
            va = (va + 1) >>> 1;
            vb = (vb + 1) >>> 1;
        end
        o = 1'b0;
        a = sat(va, o);
        b = sat(vb, o);
    endfunction

    function automatic logic [YW-1:0] model_y(input logic sc, l, m, output logic ov);
        int a[NB], b[NB], y[NY];
        logic o;
        logic [YW-1:0] r;
        int t;
        ov = 1'b0;
        for (int k = 0; k < NB; k++) begin
            ref_lane(sx0[k], sx1[k], sx2[k], scs[k], ss[k], sc, a[k], b[k], o);
            ov = ov | o;
        end
        for (int k = 0; k < NB; k++) begin
            if (l) begin
                y[2*k] = a[k]; y[2*k+1] = b[k];
            end else if (m) begin
                y[k] = a[NB-1-k]; y[NB+k] = b[NB-1-k];
            end else begin
                y[k] = a[k]; y[NB+k] = b[k];
            end
        end
        for (int j = 0; j < NY; j++) begin
            t = y[j];
            r[j*D +: D] = t[D-1:0];
        end
        return r;
    endfunction

    function automatic logic [YW-1:0] pack4(input int a, b, c, d);
        logic [YW-1:0] r;
        int t;
        t = a; r[0*D +: D] = t[D-1:0];
        t = b; r[1*D +: D] = t[D-1:0];
        t = c; r[2*D +: D] = t[D-1:0];
        t = d; r[3*D +: D] = t[D-1:0];
        return r;
    endfunction

    task automatic put_bus();
        int t;
        for (int k = 0; k < NB; k++) begin
            t = sx0[k]; bus.iX0[k*D +: D] = t[D-1:0];
            t = sx1[k]; bus.iX1[k*D +: D] = t[D-1:0];
            t = sx2[k]; bus.iX2[k*D +: D] = t[D-1:0];
            t = scs[k]; bus.iCOS[k*W +: W] = t[W-1:0];
            t = ss[k];  bus.iSIN[k*W +: W] = t[W-1:0];
        end
    endtask

    task automatic send(input logic sc, l, m, input logic push);
        exp_t e;
        logic ov;
        put_bus();
        bus.iSCALE = sc;
        bus.iST_LAST = l;
        bus.i2ND_PART_SUBSEC = m;
        bus.iVALID = 1'b1;
        if (push) begin
            e.y = model_y(sc, l, m, ov);
            sticky = sticky | ov;
            e.ov = sticky;
            e.due = cyc + 4;
            q.push_back(e);
        end
    endtask

    task automatic gen_rand();
        int m;
        for (int k = 0; k < NB; k++) begin
            sx0[k] = int'($urandom_range(0, 131071)) - 65536;
            sx1[k] = int'($urandom_range(0, 131071)) - 65536;
            sx2[k] = int'($urandom_range(0, 131071)) - 65536;
            m = int'($urandom_range(0, 1024));
            scs[k] = ($urandom_range(0, 1) == 1) ? m : -m;
            m = int'($urandom_range(0, 1024 - m));
            ss[k] = ($urandom_range(0, 1) == 1) ? m : -m;
            if ($urandom_range(0, 7) == 0) begin
                sx0[k] = 65535; sx1[k] = -65536; scs[k] = -1024; ss[k] = 0;
            end
        end
    endtask

    task automatic set_sat();
        for (int k = 0; k < NB; k++) begin
            sx0[k] = 65535; sx1[k] = 65535; sx2[k] = 0; scs[k] = 1024; ss[k] = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge iCLK);
        chk_i("drain", q.size(), 0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic got;
        int t0;
        v = tbl[idx];
        sx0[0] = v.x0a; sx0[1] = v.x0b; sx1[0] = v.x1a; sx1[1] = v.x1b;
        sx2[0] = v.x2a; sx2[1] = v.x2b; scs[0] = v.c0; scs[1] = v.c1;
        ss[0] = v.s0; ss[1] = v.s1;
        @(negedge iCLK);
        send(v.sc[0], v.lst[0], v.mir[0], 1'b0);
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge iCLK);
            bus.iVALID = 1'b0;
            if (bus.oVALID) got = 1'b1;
        end
        chk_i($sformatf("vec%0d_lat", idx), cyc - t0, 4);
        chk_y($sformatf("vec%0d_y", idx), bus.oY, pack4(v.y0, v.y1, v.y2, v.y3));
        chk_i($sformatf("vec%0d_ovf", idx), int'(bus.oOVF), v.ovf);
        @(negedge iCLK);
        chk_i($sformatf("vec%0d_strobe", idx), int'(bus.oVALID), 0);
    endtask

    always @(negedge iCLK) begin
        if (mon_en) begin
            if (bus.oVALID) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid: got oVALID=1 at cycle %0d expected 0", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk_i("sb_lat", cyc, e.due);
                    chk_y("sb_y", bus.oY, e.y);
                    chk_i("sb_ovf", int'(bus.oOVF), int'(e.ov));
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_valid: got oVALID=0 at cycle %0d expected 1", cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{100, 0, 50, 0, 7, 0, 1024, 0, 0, 0, 0, 0, 0, 150, 0, 50, 0, 0};
        tbl[1]  = '{0, 0, -3, 0, 0, 0, 512, 0, 0, 0, 0, 0, 0, -1, 0, 1, 0, 0};
        tbl[2]  = '{101, 0, 50, 0, 0, 0, 1024, 0, 0, 0, 1, 0, 0, 76, 0, 26, 0, 0};
        tbl[3]  = '{0, 10, 0, -7, 100, 0, 0, 1024, -512, 0, 0, 0, 0, -50, 3, 50, 17, 0};
        tbl[4]  = '{2, 6, 1, 1, 0, 0, -1024, -1024, 0, 0, 1, 0, 0, 1, 3, 2, 4, 0};
        tbl[5]  = '{2, 6, 1, 1, 0, 0, -1024, -1024, 0, 0, 1, 0, 1, 3, 1, 4, 2, 0};
        tbl[6]  = '{2, 6, 1, 1, 0, 0, -1024, -1024, 0, 0, 1, 1, 1, 1, 2, 3, 4, 0};
        tbl[7]  = '{2, 6, 1, 1, 0, 0, -1024, -1024, 0, 0, 1, 1, 0, 1, 2, 3, 4, 0};
        tbl[8]  = '{65535, 0, 65535, 0, 0, 0, 1024, 0, 0, 0, 0, 0, 0, 65535, 0, 0, 0, 1};
        tbl[9]  = '{-65536, 0, 65535, 0, 0, 0, 1024, 0, 0, 0, 0, 0, 0, -1, 0, -65536, 0, 1};
        tbl[10] = '{100, 0, 50, 0, 7, 0, 1024, 0, 0, 0, 0, 0, 0, 150, 0, 50, 0, 1};

        bus.iVALID = 1'b0; bus.iST_LAST = 1'b0; bus.i2ND_PART_SUBSEC = 1'b0;
        bus.iSCALE = 1'b0; bus.iCLR_OVF = 1'b0;
        bus.iX0 = '0; bus.iX1 = '0; bus.iX2 = '0; bus.iCOS = '0; bus.iSIN = '0;

        repeat (2) @(negedge iCLK);
        chk_i("rst_valid", int'(bus.oVALID), 0);
        chk_y("rst_y", bus.oY, '0);
        chk_i("rst_ovf", int'(bus.oOVF), 0);
        iRESET = 1'b1;
        @(negedge iCLK);

        for (int i = 0; i < 11; i++) run_vec(i);

        @(negedge iCLK); bus.iCLR_OVF = 1'b1;
        @(negedge iCLK); bus.iCLR_OVF = 1'b0;
        chk_i("ovf_clear", int'(bus.oOVF), 0);

        set_sat();
        @(negedge iCLK); send(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge iCLK); bus.iVALID = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK); bus.iCLR_OVF = 1'b1;
        @(negedge iCLK); bus.iCLR_OVF = 1'b0;
        chk_i("coinc_valid", int'(bus.oVALID), 1);
        chk_i("coinc_ovf", int'(bus.oOVF), 1);

        @(negedge iCLK); bus.iCLR_OVF = 1'b1;
        @(negedge iCLK); bus.iCLR_OVF = 1'b0;
        chk_i("ovf_clear2", int'(bus.oOVF), 0);
        sticky = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            if (i == 2) begin
                bus.iVALID = 1'b0;
            end else begin
                gen_rand();
                send(1'b0, (i % 3) == 2, (i % 3) == 1, 1'b1);
            end
        end
        @(negedge iCLK); bus.iVALID = 1'b0;
        drain();

        for (int i = 0; i < 300; i++) begin
            @(negedge iCLK);
            if ($urandom_range(0, 3) == 0) begin
                bus.iVALID = 1'b0;
            end else begin
                gen_rand();
                send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b1);
            end
        end
        @(negedge iCLK); bus.iVALID = 1'b0;
        drain();

        set_sat();
        @(negedge iCLK); send(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge iCLK); bus.iVALID = 1'b0;
        drain();
        @(negedge iCLK); send(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge iCLK); send(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge iCLK); bus.iVALID = 1'b0; iRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            chk_i("inrst_valid", int'(bus.oVALID), 0);
        end
        iRESET = 1'b1;
        sticky = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            chk_i("postrst_valid", int'(bus.oVALID), 0);
        end
        chk_y("postrst_y", bus.oY, '0);
        chk_i("postrst_ovf", int'(bus.oOVF), 0);

        gen_rand();
        @(negedge iCLK); send(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge iCLK); bus.iVALID = 1'b0;
        drain();

        repeat (3) @(negedge iCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
